div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle iterative divider controller for the 5-stage MIPS pipeline. It accepts a divide operation from the execute stage when the decoded ALU control is 3'b011, runs a one-bit-per-cycle restoring division, and holds the pipeline with a stall request until the result is ready. It sits beside the ALU in EX. Its stall output is ORed into the hazard unit's IF/ID/EX stall.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX holds a valid div instruction (ALUControlE == 3'b011)
- flush  in  1  synchronous abort of the in-flight divide
- dividend  in  WIDTH  SrcAE
- divisor  in  WIDTH  SrcBE
- stall  out  1  pipeline stall request (combinational)
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse: result valid this cycle
- quotient  out  WIDTH  registered quotient
- remainder  out  WIDTH  registered remainder
- div_by_zero  out  1  registered, set when the last divide had divisor == 0

## Operation
- FSM with three states: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values of the registered outputs: quotient = 0, remainder = 0, done = 0, div_by_zero = 0, busy = 0. stall is forced to 0 while rst is high.
- IDLE:
  - If start = 1 and flush = 0, the block latches both operands and clears the bit counter.
  - If divisor ≠ 0, the next state is RUN.
  - If divisor = 0, the next state is DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN:
  - Each cycle performs one restoring step. The partial remainder is shifted left by 1 and the next dividend MSB is brought in.
  - If partial remainder ≥ divisor, the divisor is subtracted and quotient bit 1 is recorded; otherwise quotient bit 0.
  - The counter increments each step. After WIDTH steps the next state is DONE.
  - div_by_zero is cleared on entry to RUN.
- DONE:
  - done = 1, and quotient/remainder are valid. The next state is IDLE unconditionally.
  - start is ignored in DONE, because the same instruction is still in EX and leaves at this edge.
- stall = (IDLE & start & ~flush) | RUN. stall is 0 in DONE.
- quotient, remainder and div_by_zero hold their values until the next accepted start.
- flush:
  - In RUN, the next state is IDLE. done is not pulsed, and the result registers keep their previous values.
  - In IDLE, a start in the same cycle is not accepted.
  - In DONE, flush has no effect.
- Arithmetic uses a WIDTH+1-bit partial remainder so the compare/subtract cannot overflow.

## Timing
- Start is accepted at edge E0. RUN covers cycles 1..WIDTH. DONE is cycle WIDTH+1.
- stall is high for WIDTH+1 cycles: the accept cycle plus the RUN cycles.
- The div instruction leaves EX at the edge that ends DONE.
- Divide by zero: accept cycle (stall = 1), then DONE in the next cycle. The stall lasts 1 cycle.
- Back-to-back divides: a new start is accepted in the IDLE cycle that follows DONE. There is no zero-bubble overlap.
- Asynchronous reset mid-RUN: the block immediately returns to IDLE, stall drops, and all registered outputs clear.

## Configuration
- DIV_SIGNED_EN defined:
  - Operands are two's complement. The divider works on the magnitudes.
  - The quotient is negated when the operand signs differ; it truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Minimum-value / −1 gives quotient = 0x80000000 (for WIDTH = 32) and remainder = 0.
- DIV_SIGNED_EN undefined: operands and results are unsigned and no sign logic is generated.
- Divide-by-zero results are identical in both modes.

## Test plan
- 100 / 7 (WIDTH = 32) -> stall high 33 cycles, done pulses in cycle 33 after accept, quotient = 14, remainder = 2, div_by_zero = 0.
- 5 / 0 -> stall high 1 cycle, done in next cycle, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
- Sign handling, 0xFFFFFFF9 / 2:
  - with DIV_SIGNED_EN: quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF;
  - without: quotient = 0x7FFFFFFC, remainder = 1.
- Start 1000 / 3, assert flush in RUN cycle 10 -> next cycle IDLE, stall = 0, no done, quotient/remainder unchanged from the prior result.
- Assert rst in RUN cycle 5 of 50 / 5 -> stall = 0 immediately, all outputs 0, then 50 / 5 from IDLE gives quotient = 10, remainder = 0.
- Two back-to-back divides, 9 / 2 then 8 / 4, start held by the stalled EX -> second accepted in the IDLE cycle after the first DONE; results 4 r 1 then 2 r 0, exactly two done pulses.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: restoring divider with pipeline stall, one quotient bit per cycle; DIV_SIGNED_EN selects signed operands
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] partRem, work, dvs, magA, magB, nextRem, nextQuo, resQ, resR;
  logic [WIDTH:0] shifted, diff;
  logic accept, lastStep, zeroDiv, ge;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign accept = state == IDLE && start && !flush;
  assign stall = !rst && (accept || busy);
  assign zeroDiv = divisor == '0;
  assign lastStep = cnt == CW'(WIDTH - 1);
  // Sign bit of the WIDTH+1-bit difference is the borrow: clear means partRem >= divisor.
  assign shifted = {partRem, work[WIDTH-1]};
  assign diff = shifted - {1'b0, dvs};
  assign ge = !diff[WIDTH];
  assign nextRem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign nextQuo = {work[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
  logic negQ, negR;
  assign magA = dividend[WIDTH-1] ? -dividend : dividend;
  assign magB = divisor[WIDTH-1] ? -divisor : divisor;
  assign resQ = negQ ? -nextQuo : nextQuo;
  assign resR = negR ? -nextRem : nextRem;
  always_ff @(posedge clk or posedge rst)
    if (rst) {negQ, negR} <= '0;
    else if (accept) {negQ, negR} <= {dividend[WIDTH-1] ^ divisor[WIDTH-1], dividend[WIDTH-1]};
`else
  assign magA = dividend;
  assign magB = divisor;
  assign resQ = nextQuo;
  assign resR = nextRem;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      partRem <= '0;
      work <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      partRem <= '0;
      work <= magA;
      dvs <= magB;
      state <= zeroDiv ? DONE : RUN;
      div_by_zero <= zeroDiv;
      if (zeroDiv) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (busy) begin
      if (flush) state <= IDLE;
      else begin
        cnt <= cnt + CW'(1);
        partRem <= nextRem;
        work <= nextQuo;
        if (lastStep) begin
          state <= DONE;
          quotient <= resQ;
          remainder <= resR;
        end
      end
    end else if (done) state <= IDLE;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: table-driven and scoreboarded checks of div_sequencer timing, results, flush and reset
module tb_div_sequencer;
  localparam int W = 32;
  logic clk = 1'b0, rst, start, flush;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic stall, busy, done, div_by_zero;
  int checks = 0, failures = 0, doneCnt = 0, prevDone;
  typedef struct { logic [W-1:0] a, b, q, r; logic z; } vec_t;
  vec_t tbl[9];
  vec_t sb[$];

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .dividend(dividend), .divisor(divisor), .stall(stall), .busy(busy),
    .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (!rst && done) doneCnt++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, b, q, r, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.z = z;
    return v;
  endfunction

  function automatic vec_t model(input logic [W-1:0] a, b);
    vec_t v;
    v.a = a; v.b = b; v.z = (b == 0);
    if (b == 0) begin v.q = '1; v.r = a; end
`ifdef DIV_SIGNED_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin v.q = a; v.r = 0; end
    else begin v.q = $signed(a) / $signed(b); v.r = $signed(a) % $signed(b); end
`else
    else begin v.q = a / b; v.r = a % b; end
`endif
    return v;
  endfunction

  task automatic waitDone(input string tag);
    int n = 0;
    bit got = 0;
    vec_t e;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (done) begin
        got = 1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s: done with empty scoreboard", tag);
        end else begin
          e = sb.pop_front();
          chk({tag, " quotient"}, quotient, e.q);
          chk({tag, " remainder"}, remainder, e.r);
          chk({tag, " div_by_zero"}, div_by_zero, e.z);
          chk({tag, " stall cycles"}, n, (e.b == 0) ? 1 : W + 1);
          chk({tag, " stall in done"}, stall, 0);
        end
      end else begin
        if (stall) n++;
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s: timeout got no done expected done", tag);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    dividend = v.a; divisor = v.b; start = 1'b1;
    sb.push_back(v);
    waitDone(tag);
    start = 1'b0;
    @(negedge clk); #1;
    chk({tag, " done once"}, done, 0);
    chk({tag, " idle after"}, busy, 0);
  endtask

  initial begin
    tbl[0] = mk(100, 7, 14, 2, 0);
    tbl[1] = mk(5, 0, 32'hFFFF_FFFF, 5, 1);
`ifdef DIV_SIGNED_EN
    tbl[2] = mk(32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    tbl[3] = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
`else
    tbl[2] = mk(32'hFFFF_FFF9, 2, 32'h7FFF_FFFC, 1, 0);
    tbl[3] = mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0);
`endif
    tbl[4] = mk(7, 100, 0, 7, 0);
    tbl[5] = mk(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0);
    tbl[6] = mk(0, 5, 0, 0, 0);
    tbl[7] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0);
    tbl[8] = mk(32'hFFFF_FFF9, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
    rst = 1'b1; start = 1'b1; flush = 1'b0; dividend = 100; divisor = 7;
    #1;
    chk("stall in reset", stall, 0);
    repeat (2) @(negedge clk);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 9; i++) runVec(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i % 2 == 1) ? W'($urandom_range(1, 255)) : W'($urandom);
      runVec(model(a, b), $sformatf("rnd%0d", i));
    end
    // flush in RUN cycle 10 must leave the previous 100/7 result untouched
    runVec(tbl[0], "preflush");
    prevDone = doneCnt;
    @(negedge clk);
    dividend = 1000; divisor = 3; start = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("flush run cycle busy", busy, 1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    chk("flush busy", busy, 0);
    chk("flush stall", stall, 0);
    chk("flush done", done, 0);
    chk("flush quotient", quotient, 14);
    chk("flush remainder", remainder, 2);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush no done", doneCnt - prevDone, 0);
    dividend = 20; divisor = 4; start = 1'b1; flush = 1'b1;
    #1;
    chk("idle flush stall", stall, 0);
    @(negedge clk); #1;
    chk("idle flush busy", busy, 0);
    start = 1'b0; flush = 1'b0;
    // async reset in RUN cycle 5
    @(negedge clk);
    dividend = 50; divisor = 5; start = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst stall", stall, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst div_by_zero", div_by_zero, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    runVec(mk(50, 5, 10, 0, 0), "after rst");
    // back-to-back: EX holds start through DONE, next div enters in the following IDLE cycle
    prevDone = doneCnt;
    @(negedge clk);
    dividend = 9; divisor = 2; start = 1'b1;
    sb.push_back(mk(9, 2, 4, 1, 0));
    waitDone("b2b first");
    dividend = 8; divisor = 4;
    sb.push_back(mk(8, 4, 2, 0, 0));
    @(negedge clk); #1;
    chk("b2b accept idle", busy, 0);
    chk("b2b accept stall", stall, 1);
    waitDone("b2b second");
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b done pulses", doneCnt - prevDone, 2);
    chk("scoreboard empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
